pipe_stall_ctrl: RTL and testbench
==================================

# pipe_stall_ctrl

Central stall/flush sequencer for the 5-stage MIPS pipeline. It merges the hazard unit's load-use/branch-operand stall request, the ID-stage branch/jump redirect, and multi-cycle instruction/data memory wait signals. From these it produces the per-stage pipeline-register write enables, the bubble/flush controls and the PC write enable. It tracks wrong-path fetches across memory waits and flags stalls that never resolve.

## Interface

**Parameters**
- `MAX_STALL`, default 64: consecutive stalled cycles before `stall_timeout` sets.
- `CNT_W`, default 32: width of the performance counters.

**Ports**
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `hazard_stall` in 1: hazard unit requests an ID hold (the inverse of its PC/IF_ID write).
- `branch_taken` in 1: instruction in ID redirects the PC this cycle (beq/bne taken, j, jal, jr).
- `imem_busy` in 1: instruction fetch is not complete this cycle.
- `dmem_busy` in 1: data access in MEM is not complete this cycle.
- `pc_write` out 1: PC register load enable.
- `if_id_write` out 1: IF/ID load enable.
- `if_id_flush` out 1: IF/ID loads a NOP (overrides the write).
- `id_ex_write` out 1: ID/EX load enable.
- `id_ex_flush` out 1: ID/EX loads a bubble.
- `ex_mem_write` out 1: EX/MEM load enable.
- `mem_wb_flush` out 1: MEM/WB loads a bubble.
- `state` out 2: 0=RUN, 1=DWAIT, 2=IWAIT.
- `stall_timeout` out 1: sticky error flag.

## Operation

Outputs are combinational functions of the registered state, `redir_pend` and the current inputs (Mealy). Next-state logic is evaluated in strict priority order.

1. **`rst`**
   - Writes: all 0.
   - Flushes: all 1.
   - Next: state RUN, `redir_pend`=0, stall counter 0, `stall_timeout`=0, perf counters 0.
2. **`dmem_busy`**
   - Full freeze: `pc_write`, `if_id_write`, `id_ex_write`, `ex_mem_write` all 0.
   - `mem_wb_flush`=1; other flushes 0.
   - Next state DWAIT. `branch_taken` and `hazard_stall` are ignored because ID is frozen and will re-assert them.
3. **`imem_busy`**
   - `pc_write`=0, `if_id_flush`=1; downstream stages advance.
   - If `hazard_stall`: additionally `if_id_write`=0, `id_ex_flush`=1, and `if_id_flush`=0 (the instruction held in ID is kept).
   - Else if `branch_taken`: `pc_write`=1 (PC takes the target while the stale fetch is in flight) and `redir_pend` is set.
   - Next state IWAIT.
4. **`redir_pend` and fetch done**
   - `if_id_flush`=1 squashes the stale returned instruction.
   - `pc_write`=0 so fetch restarts at the target.
   - `redir_pend` clears. Next state RUN.
5. **`hazard_stall`**
   - `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1.
   - `branch_taken` is ignored, because the operands are not ready.
6. **`branch_taken`**
   - `if_id_flush`=1; all writes 1.
7. **Otherwise**
   - All writes 1, all flushes 0. State RUN.

**Stall counter** (saturating)
- Increments on every cycle where `pc_write`=0 and `rst`=0. Clears on any cycle with `pc_write`=1.
- When it reaches `MAX_STALL`, `stall_timeout` sets. It clears only on `rst`.

**Exclusivity**
- `if_id_write` and `if_id_flush` are never both 1.
- `id_ex_write`=1 whenever `id_ex_flush`=1.

## Timing

- Zero-cycle latency from inputs to controls. Registered state and flags update on the rising edge.
- DWAIT/IWAIT exit takes effect in the same cycle the corresponding busy input falls.
- A `dmem_busy` arriving while `redir_pend`=1 preserves `redir_pend` until the freeze ends.
- `stall_timeout` rises on the edge at which the count equals `MAX_STALL`. That is the first cycle after the `MAX_STALL`-th consecutive stalled cycle.
- A `rst` asserted mid-wait returns all registered state to reset values on the next edge, regardless of the busy inputs.

## Configuration

`PIPE_PERF_CNT_EN`
- **Defined:** adds three `CNT_W`-bit wrapping output counters, all 0 on reset:
  - `perf_stall_cyc`: cycles with `pc_write`=0.
  - `perf_flush_cnt`: cycles with `if_id_flush`=1.
  - `perf_mem_wait`: cycles in DWAIT or IWAIT.
- **Undefined:** these ports and their registers are absent. All other behaviour is identical.

## Test plan

- **Reset:** hold `rst` 2 cycles with all inputs 1.
  - Required: all writes 0, all flushes 1, then `state`=0 and `stall_timeout`=0 after release.
- **Load-use stall:** `hazard_stall` for 1 cycle.
  - Required: `pc_write`=0, `if_id_write`=0, `id_ex_flush`=1 for exactly that cycle, then normal flow.
- **Data-memory freeze with branch:** `dmem_busy` for 3 cycles with `branch_taken`=1 throughout.
  - During the 3 cycles: all writes 0, `mem_wb_flush`=1, `state`=1, no `if_id_flush`.
  - On release: `if_id_flush`=1.
- **Redirect during fetch wait:** `imem_busy` for 2 cycles with `branch_taken` in the first.
  - Cycle 1: `pc_write`=1.
  - Cycle 2: `pc_write`=0.
  - First non-busy cycle: `if_id_flush`=1 and `pc_write`=0.
  - Following cycle: `pc_write`=1.
- **Timeout:** `MAX_STALL`=4 and `hazard_stall` held for 6 cycles.
  - Required: `stall_timeout` rises after the 4th cycle and stays high after `hazard_stall` drops until `rst`.
- **Perf counters** (`PIPE_PERF_CNT_EN` defined): run the previous two scenarios after reset.
  - Required: `perf_mem_wait`=2, `perf_flush_cnt`≥1, and `perf_stall_cyc` equals the observed number of cycles with `pc_write`=0.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges hazard, redirect and memory waits.
// Define PIPE_PERF_CNT_EN to add the perf_stall_cyc/perf_flush_cnt/perf_mem_wait counters.
module pipe_stall_ctrl #(
  parameter int MAX_STALL = 64,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_stall,
  input  logic             branch_taken,
  input  logic             imem_busy,
  input  logic             dmem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_write,
  output logic             id_ex_flush,
  output logic             ex_mem_write,
  output logic             mem_wb_flush,
  output logic [1:0]       state,
  output logic             stall_timeout
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_stall_cyc,
  output logic [CNT_W-1:0] perf_flush_cnt,
  output logic [CNT_W-1:0] perf_mem_wait
`endif
);

  localparam int SC_W = $clog2(MAX_STALL + 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    IWAIT = 2'd2
  } state_t;

  state_t          cur_state;
  state_t          next_state;
  logic            redir_pend;
  logic            next_redir;
  logic [SC_W-1:0] stall_cnt;

  assign state = cur_state;

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_write = 1'b1;
    mem_wb_flush = 1'b0;
    next_state   = RUN;
    next_redir   = redir_pend;
    if (rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      mem_wb_flush = 1'b1;
      next_redir   = 1'b0;
    end else if (dmem_busy) begin
      // ID is frozen, so a pending redirect survives and branch/hazard will re-assert
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_flush = 1'b1;
      next_state   = DWAIT;
    end else if (imem_busy) begin
      pc_write    = 1'b0;
      if_id_flush = 1'b1;
      next_state  = IWAIT;
      if (hazard_stall) begin
        if_id_write = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b1;
      end else if (branch_taken) begin
        pc_write   = 1'b1;
        next_redir = 1'b1;
      end
    end else if (redir_pend) begin
      // the fetch that just returned is from the wrong path
      pc_write    = 1'b0;
      if_id_flush = 1'b1;
      next_redir  = 1'b0;
    end else if (hazard_stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end else if (branch_taken) begin
      if_id_flush = 1'b1;
    end
    if (if_id_flush) begin
      if_id_write = 1'b0;
    end
  end

  // State, redirect tracking and the saturating stall watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state     <= RUN;
      redir_pend    <= 1'b0;
      stall_cnt     <= '0;
      stall_timeout <= 1'b0;
    end else begin
      cur_state  <= next_state;
      redir_pend <= next_redir;
      if (pc_write) begin
        stall_cnt <= '0;
      end else if (stall_cnt != SC_W'(MAX_STALL)) begin
        stall_cnt <= stall_cnt + SC_W'(1);
      end
      if (!pc_write && (stall_cnt == SC_W'(MAX_STALL - 1))) begin
        stall_timeout <= 1'b1;
      end
    end
  end

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cyc <= '0;
      perf_flush_cnt <= '0;
      perf_mem_wait  <= '0;
    end else begin
      if (!pc_write) begin
        perf_stall_cyc <= perf_stall_cyc + CNT_W'(1);
      end
      if (if_id_flush) begin
        perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
      end
      if (cur_state != RUN) begin
        perf_mem_wait <= perf_mem_wait + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: directed test-plan scenarios then random traffic,
// checked against a rule-level reference model.
module tb_pipe_stall_ctrl;

  localparam int MAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hazard_stall = 1'b0;
  logic branch_taken = 1'b0;
  logic imem_busy = 1'b0;
  logic dmem_busy = 1'b0;
  logic pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_flush;
  logic [1:0] state;
  logic stall_timeout;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_stall_cyc, perf_flush_cnt, perf_mem_wait;
`endif

  pipe_stall_ctrl #(.MAX_STALL(MAX), .CNT_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .hazard_stall(hazard_stall),
    .branch_taken(branch_taken),
    .imem_busy(imem_busy),
    .dmem_busy(dmem_busy),
    .pc_write(pc_write),
    .if_id_write(if_id_write),
    .if_id_flush(if_id_flush),
    .id_ex_write(id_ex_write),
    .id_ex_flush(id_ex_flush),
    .ex_mem_write(ex_mem_write),
    .mem_wb_flush(mem_wb_flush),
    .state(state),
    .stall_timeout(stall_timeout)
`ifdef PIPE_PERF_CNT_EN
    ,
    .perf_stall_cyc(perf_stall_cyc),
    .perf_flush_cnt(perf_flush_cnt),
    .perf_mem_wait(perf_mem_wait)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] ctrl;
    logic [1:0] st;
    logic       to;
    int         ps;
    int         pf;
    int         pm;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;

  // Reference model: wait kind (0 none, 1 data, 2 fetch), pending squash, run of stalled cycles
  int m_wait = 0;
  bit m_pend = 1'b0;
  int m_run = 0;
  bit m_to = 1'b0;
  int m_ps = 0;
  int m_pf = 0;
  int m_pm = 0;

  // ctrl bit order: pc_w, if_id_w, if_id_f, id_ex_w, id_ex_f, ex_mem_w, mem_wb_f
  task automatic modelStep(input bit r, input bit hs, input bit bt, input bit ib, input bit db,
                           output exp_t e);
    logic [6:0] c;
    if (r)                c = 7'b0010101;
    else if (db)          c = 7'b0000001;
    else if (ib && hs)    c = 7'b0001110;
    else if (ib && bt)    c = 7'b1011010;
    else if (ib)          c = 7'b0011010;
    else if (m_pend)      c = 7'b0011010;
    else if (hs)          c = 7'b0001110;
    else if (bt)          c = 7'b1011010;
    else                  c = 7'b1101010;
    e.ctrl = c;
    e.st = 2'(m_wait);
    e.to = m_to;
    e.ps = m_ps;
    e.pf = m_pf;
    e.pm = m_pm;
    if (r) begin
      m_wait = 0; m_pend = 1'b0; m_run = 0; m_to = 1'b0;
      m_ps = 0; m_pf = 0; m_pm = 0;
    end else begin
      if (!c[6]) m_ps++;
      if (c[4]) m_pf++;
      if (m_wait != 0) m_pm++;
      m_run = c[6] ? 0 : m_run + 1;
      if (m_run >= MAX) m_to = 1'b1;
      if (db) m_wait = 1;
      else if (ib) begin
        m_wait = 2;
        if (bt && !hs) m_pend = 1'b1;
      end else begin
        m_wait = 0;
        m_pend = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus(input bit r, input bit hs, input bit bt, input bit ib, input bit db);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    hazard_stall = hs;
    branch_taken = bt;
    imem_busy = ib;
    dmem_busy = db;
    modelStep(r, hs, bt, ib, db, e);
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [6:0] got;
    got = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_flush};
    total++;
    if (got !== e.ctrl) begin
      bad++;
      $display("[TB] FAIL ctrl t=%0t got=%b want=%b", $time, got, e.ctrl);
    end
    total++;
    if (state !== e.st) begin
      bad++;
      $display("[TB] FAIL state t=%0t got=%0d want=%0d", $time, state, e.st);
    end
    total++;
    if (stall_timeout !== e.to) begin
      bad++;
      $display("[TB] FAIL timeout t=%0t got=%b want=%b", $time, stall_timeout, e.to);
    end
`ifdef PIPE_PERF_CNT_EN
    total++;
    if (perf_stall_cyc !== 32'(e.ps) || perf_flush_cnt !== 32'(e.pf) || perf_mem_wait !== 32'(e.pm)) begin
      bad++;
      $display("[TB] FAIL perf t=%0t got=%0d/%0d/%0d want=%0d/%0d/%0d", $time,
               perf_stall_cyc, perf_flush_cnt, perf_mem_wait, e.ps, e.pf, e.pm);
    end
`endif
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0);
  endtask

  initial begin : stimulus
    repeat (2) @(posedge clk);
    applyStimulus(1, 1, 1, 1, 1);
    applyStimulus(1, 1, 1, 1, 1);
    idle(2);
    applyStimulus(0, 1, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 1);
    applyStimulus(0, 0, 1, 0, 0);
    idle(2);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 1, 0);
    idle(3);
    for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 0, 0);
    idle(3);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    idle(3);
    for (int i = 0; i < 800; i++) begin
      applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                    $urandom_range(0, 5) == 0);
    end
    repeat (3) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
